mult_seq_n: RTL and testbench



---
 rtl/mult_seq_n_if.sv | 13 +
 rtl/mult_seq_n.sv | 71 +++++++
 tb/tb_mult_seq_n.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mult_seq_n_if.sv
// mult_seq_n_if: activate/busy/done handshake and operand/result bus of the sequential multiplier
interface mult_seq_n_if #(parameter int WIDTH = 8);
  logic activate;
  logic sign_mode;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic busy;
  logic done;
  logic [WIDTH-1:0] mult8;
  logic [WIDTH-1:0] mult16;
  modport master(output activate, sign_mode, in1, in2, input busy, done, mult8, mult16);
  modport slave(input activate, sign_mode, in1, in2, output busy, done, mult8, mult16);
endinterface

// File: rtl/mult_seq_n.sv
// mult_seq_n: shift-and-add multiplier, one multiplier bit per clock, unsigned or signed via magnitudes
module mult_seq_n #(parameter int WIDTH = 8) (
  input logic clk,
  input logic reset,
  mult_seq_n_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH:0] acc;
  logic neg;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] mag;
  logic [2*WIDTH-1:0] prod;
  // magnitudes of the operands, the partial-sum add and the final signed product
  always_comb begin
    abs1 = (bus.sign_mode & bus.in1[WIDTH-1]) ? -bus.in1 : bus.in1;
    abs2 = (bus.sign_mode & bus.in2[WIDTH-1]) ? -bus.in2 : bus.in2;
    sum = acc + {1'b0, mcand & {WIDTH{mplier[0]}}};
    mag = {sum, mplier[WIDTH-1:1]};
    prod = neg ? -mag : mag;
  end
  // control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      neg <= 1'b0;
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.mult8 <= '0;
      bus.mult16 <= '0;
    end else begin
      case (state)
        IDLE: if (bus.activate) begin
          mcand <= abs1;
          mplier <= abs2;
          neg <= bus.sign_mode & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
          acc <= '0;
          cnt <= '0;
          bus.busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          acc <= {1'b0, sum[WIDTH:1]};
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIN;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            {bus.mult16, bus.mult8} <= prod;
          end
        end
        FIN: begin
          bus.done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_seq_n.sv
// tb_mult_seq_n: scoreboard bench for mult_seq_n at WIDTH 8 (directed), 16 and 3 (random)
module tb_mult_seq_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic act [3];
  logic sm [3];
  logic [31:0] a [3];
  logic [31:0] b [3];
  logic busy_o [3];
  logic done_o [3];
  logic [63:0] prod_o [3];
  int mdl [3];
  int pend [3];

  always #5 clk = ~clk;

  function automatic void chk(string tag, logic [63:0] o, logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endfunction

  function automatic logic [63:0] ref_mul(int w, logic [31:0] x, logic [31:0] y, logic s);
    longint lx;
    longint ly;
    logic [63:0] p;
    lx = longint'(x & ((32'd1 << w) - 1));
    ly = longint'(y & ((32'd1 << w) - 1));
    if (s && x[w-1]) lx = lx - (longint'(1) << w);
    if (s && y[w-1]) ly = ly - (longint'(1) << w);
    p = 64'(lx * ly);
    return p & ((64'd1 << (2 * w)) - 1);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int W = g == 0 ? 8 : g == 1 ? 16 : 3;
    typedef struct {
      logic [63:0] v;
      int c0;
    } item_t;
    item_t q [$];
    item_t e;
    int cyc = 0;
    logic [63:0] hold = '0;
    mult_seq_n_if #(.WIDTH(W)) bus ();
    mult_seq_n #(.WIDTH(W)) dut (.clk(clk), .reset(rst), .bus(bus));
    assign bus.activate = act[g];
    assign bus.sign_mode = sm[g];
    assign bus.in1 = a[g][W-1:0];
    assign bus.in2 = b[g][W-1:0];
    assign busy_o[g] = bus.busy;
    assign done_o[g] = bus.done;
    assign prod_o[g] = 64'({bus.mult16, bus.mult8});
    // cycle model: idle when mdl is 0, W RUN cycles, then one FIN cycle
    always @(posedge clk) if (!rst) begin
      cyc++;
      if (mdl[g] == 0 && act[g]) begin
        q.push_back('{ref_mul(W, a[g], b[g], sm[g]), cyc});
        mdl[g] = W + 1;
      end else if (mdl[g] > 0) mdl[g]--;
    end
    // compare handshake, latency and held result against the model
    always @(negedge clk) begin
      if (rst) begin
        mdl[g] = 0;
        q.delete();
        hold = '0;
        chk($sformatf("w%0d reset busy", W), 64'(busy_o[g]), 64'd0);
        chk($sformatf("w%0d reset done", W), 64'(done_o[g]), 64'd0);
        chk($sformatf("w%0d reset product", W), prod_o[g], 64'd0);
      end else begin
        chk($sformatf("w%0d busy", W), 64'(busy_o[g]), 64'(mdl[g] >= 2));
        chk($sformatf("w%0d done", W), 64'(done_o[g]), 64'(mdl[g] == 1));
        if (mdl[g] == 1 && q.size() > 0) begin
          e = q.pop_front();
          hold = e.v;
          chk($sformatf("w%0d latency", W), 64'(cyc - e.c0 + 1), 64'(W + 1));
        end
        chk($sformatf("w%0d product", W), prod_o[g], hold);
      end
      pend[g] = q.size();
    end
  end

  task automatic start(int g, logic [31:0] x, logic [31:0] y, logic s);
    @(negedge clk);
    a[g] = x;
    b[g] = y;
    sm[g] = s;
    act[g] = 1'b1;
    @(negedge clk);
    act[g] = 1'b0;
  endtask

  task automatic wait_idle(int g);
    int n = 0;
    while (mdl[g] != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle timeout", 64'(n < 100), 64'd1);
  endtask

  task automatic op(int g, logic [31:0] x, logic [31:0] y, logic s, logic [63:0] want, string tag);
    start(g, x, y, s);
    wait_idle(g);
    chk(tag, prod_o[0], want);
  endtask

  initial begin
    foreach (act[i]) begin
      act[i] = 1'b0;
      sm[i] = 1'b0;
      a[i] = '0;
      b[i] = '0;
    end
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    op(0, 13, 11, 1'b0, 64'h008F, "u 13x11");
    op(0, 32'hFF, 32'hFF, 1'b0, 64'hFE01, "u FFxFF");
    op(0, 32'h80, 32'h80, 1'b1, 64'h4000, "s 80x80");
    op(0, 32'hFD, 32'h05, 1'b1, 64'hFFF1, "s FDx05");
    op(0, 32'h00, 32'h80, 1'b1, 64'h0000, "s 00x80");
    op(0, 13, 11, 1'b0, 64'h008F, "u 13x11 again");
    start(0, 2, 3, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold during run", prod_o[0], 64'h008F);
    wait_idle(0);
    chk("u 2x3", prod_o[0], 64'h0006);
    start(0, 32'h7F, 32'h7F, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async reset busy", 64'(busy_o[0]), 64'd0);
    chk("async reset done", 64'(done_o[0]), 64'd0);
    chk("async reset product", prod_o[0], 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    op(0, 32'h7F, 32'h7F, 1'b0, 64'h3F01, "u 7Fx7F after reset");
    @(negedge clk);
    act[0] = 1'b1;
    repeat (50) begin
      a[0] = $urandom;
      b[0] = $urandom;
      sm[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    act[0] = 1'b0;
    wait_idle(0);
    repeat (40000) begin
      for (int k = 1; k < 3; k++) begin
        a[k] = $urandom;
        b[k] = $urandom;
        sm[k] = 1'($urandom_range(0, 1));
        act[k] = $urandom_range(0, 15) != 0;
      end
      @(negedge clk);
    end
    act[1] = 1'b0;
    act[2] = 1'b0;
    wait_idle(1);
    wait_idle(2);
    for (int k = 0; k < 3; k++) chk($sformatf("pending results %0d", k), 64'(pend[k]), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
